// File: rtl/fp_sqrt_seq.sv
// Iterative IEEE single-precision square root with round-to-nearest-even.
// One root bit per enabled clock, restoring digit recurrence, ld/done handshake.
module fp_sqrt_seq #(
    parameter int FPWID = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             ld,
    input  logic [FPWID-1:0] a,
    output logic [FPWID-1:0] o,
    output logic             done,
    output logic             busy,
    output logic             nv
);

    typedef enum logic [1:0] {IDLE, SPEC, CALC, ROUND} state_t;

    state_t      state;
    logic [49:0] rad;
    logic [24:0] root;
    logic [26:0] rem;
    logic [4:0]  cnt;
    logic [7:0]  re;

    // Operand classification
    logic        sgn;
    logic [7:0]  ea;
    logic [22:0] fa;
    logic        special;
    logic [31:0] spec_o;
    logic        spec_nv;
    logic [49:0] rad_init;
    logic [8:0]  re_sum;
    logic [7:0]  re_init;

    assign sgn = a[31];
    assign ea  = a[30:23];
    assign fa  = a[22:0];

    always_comb begin
        special = 1'b1;
        spec_o  = 32'h0000_0000;
        spec_nv = 1'b0;
        if (ea == 8'd0) begin
            // Zero and denormals are flushed to a signed zero.
            spec_o = {sgn, 31'b0};
        end else if (ea == 8'hFF && fa != 23'd0) begin
            spec_o  = a | 32'h0040_0000;
            spec_nv = ~fa[22];
        end else if (sgn) begin
            spec_o  = 32'h7FC0_0000;
            spec_nv = 1'b1;
        end else if (ea == 8'hFF) begin
            spec_o = 32'h7F80_0000;
        end else begin
            special = 1'b0;
        end
    end

    // Odd exponents are already even after unbiasing; even ones borrow a factor of two.
    always_comb begin
        if (ea[0]) begin
            rad_init = {1'b0, 1'b1, fa, 25'b0};
            re_sum   = {1'b0, ea} + 9'd127;
        end else begin
            rad_init = {1'b1, fa, 1'b0, 25'b0};
            re_sum   = {1'b0, ea} + 9'd126;
        end
        re_init = re_sum[8:1];
    end

    // One restoring step: bring down two radicand bits and try root digit 1.
    logic [28:0] rem_shift;
    logic [26:0] trial_sub;
    logic        take;
    logic [26:0] trial_diff;

    assign rem_shift  = {rem, rad[49:48]};
    assign trial_sub  = {root, 2'b01};
    assign take       = rem_shift >= {2'b00, trial_sub};
    assign trial_diff = rem_shift[26:0] - trial_sub;

    // Rounding: root[0] is the guard bit, a nonzero remainder is the sticky bit.
    logic        inc;
    logic [30:0] rounded;

    assign inc     = root[0] & ((rem != 27'd0) | root[1]);
    assign rounded = {re, root[23:1]} + {30'd0, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rad   <= '0;
            root  <= '0;
            rem   <= '0;
            cnt   <= '0;
            re    <= '0;
            o     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            nv    <= 1'b0;
        end else if (ce) begin
            done <= 1'b0;
            case (state)
                IDLE, SPEC: begin
                    state <= IDLE;
                    if (ld) begin
                        if (special) begin
                            o     <= spec_o;
                            nv    <= spec_nv;
                            done  <= 1'b1;
                            state <= SPEC;
                        end else begin
                            rad   <= rad_init;
                            re    <= re_init;
                            root  <= '0;
                            rem   <= '0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rad <= {rad[47:0], 2'b00};
                    if (take) begin
                        rem  <= trial_diff;
                        root <= {root[23:0], 1'b1};
                    end else begin
                        rem  <= rem_shift[26:0];
                        root <= {root[23:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd24) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    o     <= {1'b0, rounded};
                    nv    <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_sqrt_seq.sv
// Self-checking bench for fp_sqrt_seq: directed vectors, handshake corner cases
// and random operands against a real-arithmetic reference model.
module tb_fp_sqrt_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        ld = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] o;
    logic        done;
    logic        busy;
    logic        nv;

    int total = 0;
    int bad   = 0;

    fp_sqrt_seq #(.FPWID(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ce   (ce),
        .ld   (ld),
        .a    (a),
        .o    (o),
        .done (done),
        .busy (busy),
        .nv   (nv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] o;
        logic        nv;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: special cases from the IEEE rules, normals via double sqrt rounded to single.
    function automatic void ref_model(input logic [31:0] x, output logic [31:0] y,
                                      output logic v, output int lat);
        logic [7:0]  e;
        logic [22:0] f;
        logic [10:0] de;
        logic [63:0] db;
        logic [63:0] rb;
        logic [10:0] rexp;
        logic [22:0] keep;
        logic [28:0] rest;
        logic        up;
        real         r;
        e = x[30:23];
        f = x[22:0];
        lat = 1;
        v = 1'b0;
        y = 32'd0;
        if (e == 8'd0) begin
            y = {x[31], 31'b0};
        end else if (e == 8'hFF && f != 23'd0) begin
            y = x | 32'h0040_0000;
            v = ~x[22];
        end else if (x[31]) begin
            y = 32'h7FC0_0000;
            v = 1'b1;
        end else if (e == 8'hFF) begin
            y = 32'h7F80_0000;
        end else begin
            lat = 27;
            de = {3'b000, e} + 11'd896;
            db = {1'b0, de, f, 29'b0};
            r = $sqrt($bitstoreal(db));
            rb = $realtobits(r);
            rexp = rb[62:52] - 11'd896;
            keep = rb[51:29];
            rest = rb[28:0];
            up = (rest > 29'h1000_0000) || (rest == 29'h1000_0000 && keep[0]);
            y = {1'b0, rexp[7:0], keep} + {31'd0, up};
        end
    endfunction

    // Issue one ld (ce=1 assumed) and count enabled edges until done, bounded.
    task automatic run_op(input logic [31:0] x, output logic [31:0] y, output logic v, output int lat);
        @(negedge clk);
        a  = x;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld  = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = o;
        v = nv;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] ro;
    logic        rv;
    int          rl;
    logic [31:0] eo;
    logic        ev;
    int          el;
    logic [31:0] x;
    int          seen;

    initial begin
        vecs.push_back('{32'h4080_0000, 32'h4000_0000, 1'b0, 27});
        vecs.push_back('{32'h4000_0000, 32'h3FB5_04F3, 1'b0, 27});
        vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b0, 27});
        vecs.push_back('{32'h4110_0000, 32'h4040_0000, 1'b0, 27});
        vecs.push_back('{32'hBF80_0000, 32'h7FC0_0000, 1'b1, 1});
        vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b0, 1});
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1});
        vecs.push_back('{32'h7F80_0001, 32'h7FC0_0001, 1'b1, 1});
        vecs.push_back('{32'hFFC0_0000, 32'hFFC0_0000, 1'b0, 1});
        vecs.push_back('{32'hFF80_0000, 32'h7FC0_0000, 1'b1, 1});
        vecs.push_back('{32'h7F7F_FFFF, 32'h5F7F_FFFF, 1'b0, 27});

        repeat (3) @(posedge clk);
        #1;
        check("reset_o", o, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_nv", {31'd0, nv}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, ro, rv, rl);
            $display("vec %0d a=%h o=%h nv=%0d lat=%0d", i, vecs[i].a, ro, rv, rl);
            check("vec_o", ro, vecs[i].o);
            check("vec_nv", {31'd0, rv}, {31'd0, vecs[i].nv});
            check("vec_lat", rl, vecs[i].lat);
        end

        // ld while busy is ignored; ld in the done cycle is accepted.
        @(negedge clk);
        a = 32'h4080_0000;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
        check("busy_after_ld", {31'd0, busy}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        a = 32'h4110_0000;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
        wait_done(6, rl);
        $display("busy-ld a=40800000 o=%h lat=%0d", o, rl);
        check("ignored_ld_lat", rl, 27);
        check("ignored_ld_o", o, 32'h4000_0000);
        check("done_busy", {31'd0, busy}, 32'd0);
        a = 32'h4110_0000;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
        check("b2b_done_drop", {31'd0, done}, 32'd0);
        wait_done(1, rl);
        $display("b2b a=41100000 o=%h lat=%0d", o, rl);
        check("b2b_lat", rl, 27);
        check("b2b_o", o, 32'h4040_0000);

        // Done holds while ce is low.
        @(negedge clk);
        ce = 1'b0;
        @(posedge clk);
        #1;
        check("done_hold_ce", {31'd0, done}, 32'd1);
        ce = 1'b1;
        @(posedge clk);
        #1;
        check("done_clear", {31'd0, done}, 32'd0);

        // ce low for 10 cycles during CALC.
        @(negedge clk);
        a = 32'h4000_0000;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ce = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        ce = 1'b1;
        wait_done(14, rl);
        $display("ce-stall a=40000000 o=%h lat=%0d", o, rl);
        check("stall_lat", rl, 37);
        check("stall_o", o, 32'h3FB5_04F3);

        // Reset mid-operation aborts with no later done.
        @(negedge clk);
        a = 32'h4000_0000;
        ld = 1'b1;
        @(posedge clk);
        #1;
        ld = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_o", o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        $display("abort done pulses after reset=%0d", seen);
        check("abort_no_done", seen, 0);

        // Random operands against the reference model.
        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            if (i % 4 != 0) x[31] = 1'b0;
            ref_model(x, eo, ev, el);
            run_op(x, ro, rv, rl);
            $display("rnd %0d a=%h o=%h exp=%h nv=%0d lat=%0d", i, x, ro, eo, rv, rl);
            check("rnd_o", ro, eo);
            check("rnd_nv", {31'd0, rv}, {31'd0, ev});
            check("rnd_lat", rl, el);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
